// File: rtl/leg_seq.sv
// leg_seq: multi-cycle sequencer for a tiny load/execute/write-back machine.
// Each instruction runs FETCH -> DECODE -> EXEC -> WB. The register file and
// the ALU sit outside this block, so it only drives their ports.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   run                level; 1 = keep executing, 0 = stop at the next boundary
//   imem_req/addr/ack  fetch handshake; imem_data = {op, arg1, arg2, dest}
//   imem_data          instruction word, valid while imem_ack=1
//   rf_raddr0/1        register read addresses (arg1[2:0] / arg2[2:0])
//   rf_rdata0/1        combinational register read data
//   alu_op/a/b, alu_y  ALU operation, operands and combinational result
//   rf_we/waddr/wdata  register write port, pulsed in WB
//   pc                 program counter (byte address)
//   halted, illegal    HALT state indicator, sticky illegal-opcode flag
module leg_seq #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [2:0]  rf_raddr0,
  output logic [2:0]  rf_raddr1,
  input  logic [7:0]  rf_rdata0,
  input  logic [7:0]  rf_rdata1,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_y,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [7:0]  pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StWb, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  res_q, res_d;
  logic        cond_q, cond_d;
  logic        illegal_q, illegal_d;

  logic [7:0]  opcode;
  logic [7:0]  dest;
  logic        is_calc;
  logic        is_jump;
  logic        cond_eval;
  logic        wr_reg;

  assign opcode  = ir_q[31:24];
  assign dest    = ir_q[7:0];
  assign is_calc = (opcode[5:3] == 3'b000);
  assign is_jump = (opcode[5:3] == 3'b100) && (opcode[2:0] <= 3'd5);
  // Register 6 is the program counter alias: CALC into it redirects pc instead.
  assign wr_reg  = is_calc && (dest[2:0] != 3'd6);

  // Unsigned compare of the latched operands, A op B.
  always_comb begin
    cond_eval = 1'b0;
    case (opcode[2:0])
      3'd0:    cond_eval = (a_q == b_q);
      3'd1:    cond_eval = (a_q != b_q);
      3'd2:    cond_eval = (a_q <  b_q);
      3'd3:    cond_eval = (a_q <= b_q);
      3'd4:    cond_eval = (a_q >  b_q);
      3'd5:    cond_eval = (a_q >= b_q);
      default: cond_eval = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  if (imem_ack) state_d = StDecode;
      StDecode: state_d = (is_calc || is_jump) ? StExec : StHalt;
      StExec:   state_d = StWb;
      StWb:     state_d = run ? StFetch : StIdle;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cond_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cond_q    <= cond_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cond_d    = cond_q;
    illegal_d = illegal_q;
    case (state_q)
      StFetch: begin
        if (imem_ack) ir_d = imem_data;
      end
      StDecode: begin
        a_d = opcode[7] ? ir_q[23:16] : rf_rdata0;
        b_d = opcode[6] ? ir_q[15:8]  : rf_rdata1;
        if (!(is_calc || is_jump)) illegal_d = 1'b1;
      end
      StExec: begin
        if (is_calc) res_d  = alu_y;
        else         cond_d = cond_eval;
      end
      StWb: begin
        // 8-bit add wraps modulo 256.
        if (is_calc) pc_d = wr_reg ? pc_q + 8'd4 : res_q;
        else         pc_d = cond_q ? dest : pc_q + 8'd4;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = (state_q == StFetch);
    imem_addr = pc_q;
    rf_raddr0 = ir_q[18:16];
    rf_raddr1 = ir_q[10:8];
    alu_op    = ir_q[26:24];
    alu_a     = '0;
    alu_b     = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    pc        = pc_q;
    halted    = (state_q == StHalt);
    illegal   = illegal_q;
    if (state_q == StExec) begin
      alu_a = a_q;
      alu_b = b_q;
    end
    if ((state_q == StWb) && wr_reg) begin
      rf_we    = 1'b1;
      rf_waddr = dest[2:0];
      rf_wdata = res_q;
    end
  end

endmodule

// File: tb/tb_leg_seq.sv
// Directed bench for leg_seq: small instruction memory with programmable ack
// delay, 8-entry register file and a simple ALU. All timing is fixed, so the
// bench never waits on a DUT event.
module tb_leg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [2:0]  rf_raddr0;
  logic [2:0]  rf_raddr1;
  logic [7:0]  rf_rdata0;
  logic [7:0]  rf_rdata1;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;

  logic [31:0] mem [64];
  logic [7:0]  regs [8];
  int unsigned ack_delay;
  int unsigned wait_cnt;
  int unsigned we_cnt;
  logic [2:0]  last_waddr;
  logic [7:0]  last_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  leg_seq #(.UUID(3), .NAME("u_dut")) u_dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .rf_raddr0 (rf_raddr0),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata0 (rf_rdata0),
    .rf_rdata1 (rf_rdata1),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  assign imem_ack  = imem_req && (wait_cnt >= ack_delay);
  assign imem_data = mem[imem_addr[7:2]];
  assign rf_rdata0 = regs[rf_raddr0];
  assign rf_rdata1 = regs[rf_raddr1];

  always_comb begin
    alu_y = alu_a;
    case (alu_op)
      3'd0:    alu_y = alu_a + alu_b;
      3'd1:    alu_y = alu_a - alu_b;
      3'd2:    alu_y = alu_a & alu_b;
      3'd3:    alu_y = alu_a | alu_b;
      3'd4:    alu_y = alu_a ^ alu_b;
      default: alu_y = alu_a;
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= 0;
      we_cnt     <= 0;
      last_waddr <= '0;
      last_wdata <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (!imem_req || imem_ack) wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
      if (rf_we) begin
        regs[rf_waddr] <= rf_wdata;
        we_cnt         <= we_cnt + 1;
        last_waddr     <= rf_waddr;
        last_wdata     <= rf_wdata;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned wc;
    int          cnt;

    rst       = 1'b1;
    run       = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'hC005_0302; // 0x00: ADD #5,#3 -> r2 = 8
    mem[1]  = 32'hE007_0740; // 0x04: EQ 7,7 -> jump 0x40
    mem[16] = 32'hE107_0740; // 0x40: NE 7,7 -> fall through
    mem[17] = 32'h0002_0203; // 0x44: ADD r2,r2 -> r3 = 0x10
    mem[18] = 32'h8120_0300; // 0x48: SUB #0x20,r3 -> r0 = 0x10
    mem[19] = 32'hE203_0560; // 0x4C: LT 3,5 -> jump 0x60
    mem[24] = 32'hC010_2006; // 0x60: ADD -> r6, pc = 0x30
    mem[12] = 32'hE503_0590; // 0x30: GE 3,5 -> fall through
    mem[13] = 32'hC001_0104; // 0x34: ADD -> r4 = 2
    mem[14] = 32'hE000_00FC; // 0x38: EQ 0,0 -> jump 0xFC
    mem[63] = 32'hC001_0203; // 0xFC: ADD -> r3 = 3, pc wraps to 0

    #1 rst = 1'b0;
    step(1);
    check_eq("rst_imem_req", 32'(imem_req), 32'h0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'h0);
    check_eq("rst_pc", 32'(pc), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_illegal", 32'(illegal), 32'h0);
    check_eq("rst_rf_we", 32'(rf_we), 32'h0);
    check_eq("rst_alu_a", 32'(alu_a), 32'h0);
    check_eq("rst_alu_op", 32'(alu_op), 32'h0);

    // CALC with immediates, cycle by cycle
    rst = 1'b1;
    run = 1'b1;
    step(1); // FETCH
    check_eq("calc_fetch_req", 32'(imem_req), 32'h1);
    check_eq("calc_fetch_addr", 32'(imem_addr), 32'h0);
    step(1); // DECODE
    check_eq("calc_dec_req", 32'(imem_req), 32'h0);
    check_eq("calc_dec_alu_a", 32'(alu_a), 32'h0);
    step(1); // EXEC
    check_eq("calc_exec_alu_a", 32'(alu_a), 32'h5);
    check_eq("calc_exec_alu_b", 32'(alu_b), 32'h3);
    step(1); // WB
    check_eq("calc_wb_we", 32'(rf_we), 32'h1);
    check_eq("calc_wb_waddr", 32'(rf_waddr), 32'h2);
    check_eq("calc_wb_wdata", 32'(rf_wdata), 32'h08);
    check_eq("calc_wb_alu_b", 32'(alu_b), 32'h0);
    check_eq("calc_wb_pc", 32'(pc), 32'h0);
    step(1); // next FETCH
    check_eq("calc_pc", 32'(pc), 32'h04);
    check_eq("calc_we_done", 32'(rf_we), 32'h0);
    check_eq("calc_next_addr", 32'(imem_addr), 32'h04);

    step(4);
    check_eq("jeq_pc", 32'(pc), 32'h40);
    check_eq("jeq_no_write", 32'(we_cnt), 32'd1);
    step(4);
    check_eq("jne_pc", 32'(pc), 32'h44);
    check_eq("jne_no_write", 32'(we_cnt), 32'd1);

    // Register operands
    step(2);
    check_eq("regop_alu_a", 32'(alu_a), 32'h08);
    check_eq("regop_alu_b", 32'(alu_b), 32'h08);
    step(2);
    check_eq("regop_pc", 32'(pc), 32'h48);
    check_eq("regop_waddr", 32'(last_waddr), 32'h3);
    check_eq("regop_wdata", 32'(last_wdata), 32'h10);
    step(4);
    check_eq("mixed_pc", 32'(pc), 32'h4C);
    check_eq("mixed_r0", 32'(regs[0]), 32'h10);
    step(4);
    check_eq("jlt_pc", 32'(pc), 32'h60);

    // Destination r6 redirects pc, no register write
    wc = we_cnt;
    step(4);
    check_eq("ctr_pc", 32'(pc), 32'h30);
    check_eq("ctr_no_write", 32'(we_cnt), 32'(wc));
    step(4);
    check_eq("jge_pc", 32'(pc), 32'h34);

    // Drop run during EXEC: write still completes, then IDLE
    step(2);
    run = 1'b0;
    step(1);
    check_eq("rundrop_we", 32'(rf_we), 32'h1);
    check_eq("rundrop_wdata", 32'(rf_wdata), 32'h02);
    step(1);
    check_eq("rundrop_pc", 32'(pc), 32'h38);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) cnt++;
      step(1);
    end
    check_eq("rundrop_idle_req", 32'(cnt), 32'd0);
    run = 1'b1;
    step(1);
    check_eq("resume_req", 32'(imem_req), 32'h1);
    check_eq("resume_addr", 32'(imem_addr), 32'h38);

    // Stalled fetch at 0xFC, then pc wraps to 0
    step(1); // DECODE of the jump
    ack_delay = 3;
    step(3); // first FETCH cycle at 0xFC
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req && imem_addr == 8'hFC) cnt++;
      step(1);
    end
    check_eq("stall_hold_cycles", 32'(cnt), 32'd4);
    check_eq("stall_dec_req", 32'(imem_req), 32'h0);
    ack_delay = 0;
    mem[0] = 32'h3800_0000; // illegal for the refetch at 0x00
    step(2);
    check_eq("wrap_wdata", 32'(rf_wdata), 32'h03);
    step(1);
    check_eq("wrap_pc", 32'(pc), 32'h00);

    // Illegal opcode
    wc = we_cnt;
    step(2);
    check_eq("ill_halted", 32'(halted), 32'h1);
    check_eq("ill_flag", 32'(illegal), 32'h1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || rf_we) cnt++;
      step(1);
    end
    check_eq("ill_quiet", 32'(cnt), 32'd0);
    check_eq("ill_still_halted", 32'(halted), 32'h1);
    check_eq("ill_pc", 32'(pc), 32'h00);
    check_eq("ill_no_write", 32'(we_cnt), 32'(wc));
    #2 rst = 1'b0;
    #1;
    check_eq("ill_rst_halted", 32'(halted), 32'h0);
    check_eq("ill_rst_flag", 32'(illegal), 32'h0);

    // Reset during WB drops the write at once
    mem[0] = 32'hC005_0302;
    step(1);
    rst = 1'b1;
    run = 1'b1;
    step(4); // WB
    check_eq("wbrst_we_before", 32'(rf_we), 32'h1);
    #1 rst = 1'b0;
    #1;
    check_eq("wbrst_we_after", 32'(rf_we), 32'h0);
    step(1);
    check_eq("wbrst_pc", 32'(pc), 32'h00);
    check_eq("wbrst_req", 32'(imem_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
